ib_fetch_sequencer: RTL and testbench
=====================================

Name: ib_fetch_sequencer

Overview:
- Program-counter and fetch-control stage that drives the instruction memory block's address incrementer and consumes its result.
- Holds the PC register and presents it to the incrementer as the current address, with an increment strobe; loads the incremented address back on each accepted instruction.
- Issues synchronous-read requests to instruction memory and hands fetched words to decode over a valid/ready handshake.
- Supports jump redirect and end-of-memory halt.

Parameters:
- AWIDTH, 6, instruction address width; memory depth is 2^AWIDTH words.
- DWIDTH, 32, instruction word width.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  pulse; leaves IDLE and begins fetching at the current PC.
- jump_en  input  1  redirect request; sampled every cycle.
- jump_addr  input  AWIDTH  redirect target.
- pc_addr  output  AWIDTH  current PC, driven to incrementer addr input.
- pc_inc  output  1  increment strobe to incrementer inc input.
- pc_next  input  AWIDTH  incrementer result (pc_addr + pc_inc, modulo 2^AWIDTH).
- mem_en  output  1  memory read enable.
- mem_addr  output  AWIDTH  memory read address.
- mem_data  input  DWIDTH  memory read data, valid the cycle after mem_en.
- instr  output  DWIDTH  registered instruction to decode.
- instr_pc  output  AWIDTH  address of instr.
- instr_valid  output  1  instr/instr_pc valid.
- instr_ready  input  1  decode accepts when high with instr_valid.
- halted  output  1  high in HALT state.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE, pc=0, instr=0, instr_pc=0, instr_valid=0, mem_en=0, pc_inc=0, halted=0.
  - Reset overrides all other inputs, including mid-fetch; any in-flight read is discarded.
- States: IDLE, REQ, RESP, VALID, HALT.
- IDLE: outputs idle.
  - start=1 -> REQ.
  - jump_en=1 loads pc<=jump_addr and stays in IDLE.
  - If both are high, jump takes priority: pc loads, then -> REQ.
- REQ: mem_en=1, mem_addr=pc. Next cycle -> RESP.
- RESP: at the end of this cycle capture instr<=mem_data, instr_pc<=pc; -> VALID.
- VALID: instr_valid=1; instr and instr_pc are held stable until the handshake.
  - Handshake = instr_valid & instr_ready.
  - On handshake without jump: pc_inc=1 (combinational, that cycle only), pc<=pc_next, -> REQ. Exception: pc==2^AWIDTH-1 -> HALT, and pc is not updated.
  - On handshake with jump_en: pc_inc=0, pc<=jump_addr, -> REQ.
  - No handshake: hold; jump_en is ignored.
- REQ or RESP with jump_en: in-flight fetch is flushed (no capture), pc<=jump_addr, -> REQ.
- HALT: halted=1, mem_en=0, instr_valid=0.
  - jump_en loads pc<=jump_addr and -> REQ.
  - start is ignored.
- pc_inc is 0 in every case not listed above; pc_addr=pc at all times.
- Latency and throughput: start at edge N gives mem_en during N+1, RESP at N+2, instr_valid high from N+3. Steady state is one instruction per 3 cycles with instr_ready held high.
- instr_valid drops the cycle after the handshake; it is never high in two consecutive cycles for different instructions.

Optional Feature:
- IB_FETCH_WRAP_EN
- Defined: no HALT on the last address. A handshake at pc=2^AWIDTH-1 asserts pc_inc and loads pc_next (=0), then -> REQ. HALT is unreachable and halted is tied 0.
- Undefined: halt-at-end behaviour as specified above.

Test Plan:
- Reset then start with instr_ready=1, mem[0..2]=A0,A1,A2 -> instr_valid at cycle 3 after start; instr/instr_pc = A0/0, A1/1, A2/2 every 3 cycles; pc_inc pulses once per handshake.
- instr_ready held low 5 cycles while valid -> instr and instr_pc stable, pc unchanged, pc_inc=0, mem_en=0; release -> next fetch from pc+1.
- jump_en with jump_addr=0x20 asserted during RESP of address 4 -> no instr_valid for address 4; next instr_pc=0x20.
- jump_en=1 with jump_addr=0x10 on a VALID handshake at pc=7 -> pc_inc=0, next instr_pc=0x10.
- jump_addr=63, AWIDTH=6, accept the instruction -> halted=1, no further mem_en. With IB_FETCH_WRAP_EN defined, the next instr_pc=0 instead.
- rst_n low during REQ at pc=9 -> next cycle all outputs are at reset values and pc=0; start -> fetch from 0.

Source files
------------

// File: rtl/ib_fetch_sequencer.sv
// PC register and fetch control: REQ -> RESP -> VALID per instruction, one instruction every 3 cycles at best.
// Decode backpressure holds VALID with instr/instr_pc stable; define IB_FETCH_WRAP_EN to wrap at the last address instead of halting.
module ib_fetch_sequencer #(
    parameter int AWIDTH = 6,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              jump_en,
    input  logic [AWIDTH-1:0] jump_addr,
    output logic [AWIDTH-1:0] pc_addr,
    output logic              pc_inc,
    input  logic [AWIDTH-1:0] pc_next,
    output logic              mem_en,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_data,
    output logic [DWIDTH-1:0] instr,
    output logic [AWIDTH-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              halted
);

    typedef enum logic [2:0] {IDLE, REQ, RESP, VALID, HALT} state_t;

    state_t            state;
    logic [AWIDTH-1:0] pc;

    assign pc_addr     = pc;
    assign mem_addr    = pc;
    assign mem_en      = (state == REQ);
    assign instr_valid = (state == VALID);

`ifdef IB_FETCH_WRAP_EN
    assign halted = 1'b0;
    assign pc_inc = (state == VALID) & instr_ready & ~jump_en;
`else
    localparam logic [AWIDTH-1:0] PC_LAST = '1;
    assign halted = (state == HALT);
    // The last address halts instead of incrementing, so no strobe there.
    assign pc_inc = (state == VALID) & instr_ready & ~jump_en & (pc != PC_LAST);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            instr    <= '0;
            instr_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (jump_en) pc <= jump_addr;
                    if (start) state <= REQ;
                end
                REQ: begin
                    if (jump_en) pc <= jump_addr;
                    state <= jump_en ? REQ : RESP;
                end
                RESP: begin
                    // A redirect here drops the returning word on the floor.
                    if (jump_en) begin
                        pc    <= jump_addr;
                        state <= REQ;
                    end else begin
                        instr    <= mem_data;
                        instr_pc <= pc;
                        state    <= VALID;
                    end
                end
                VALID: begin
                    if (instr_ready) begin
                        if (jump_en) begin
                            pc    <= jump_addr;
                            state <= REQ;
                        end else if (pc_inc) begin
                            pc    <= pc_next;
                            state <= REQ;
                        end else begin
                            state <= HALT;
                        end
                    end
                end
                HALT: begin
                    if (jump_en) begin
                        pc    <= jump_addr;
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ib_fetch_sequencer.sv
// Directed bench for ib_fetch_sequencer: scoreboard of expected handshakes plus inline timing checks.
module tb_ib_fetch_sequencer;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n, start, jump_en, instr_ready;
    logic [AW-1:0] jump_addr, pc_addr, pc_next, mem_addr, instr_pc;
    logic          pc_inc, mem_en, instr_valid, halted;
    logic [DW-1:0] mem_data, instr;

    typedef struct {
        logic [AW-1:0] pc;
        logic          inc;
        logic          chk_inc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    logic prev_hs = 1'b0;

    always #5 clk = ~clk;

    ib_fetch_sequencer #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .jump_en(jump_en), .jump_addr(jump_addr),
        .pc_addr(pc_addr), .pc_inc(pc_inc), .pc_next(pc_next),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .halted(halted)
    );

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return 32'hA000_0000 | {26'd0, a};
    endfunction

    // Incrementer and synchronous-read memory models
    assign pc_next = pc_addr + {{(AW-1){1'b0}}, pc_inc};
    always @(posedge clk) if (mem_en) mem_data <= word(mem_addr);

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] pc, input logic inc, input logic ci);
        exp_t e;
        e.pc = pc; e.inc = inc; e.chk_inc = ci;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
        chk("drain_timeout", {31'd0, exp_q.size() != 0}, 32'd0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 50) begin tick(); n++; end
        chk("wait_valid_timeout", {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_mem_en"},      {31'd0, mem_en},      32'd0);
        chk({tag, "_pc_inc"},      {31'd0, pc_inc},      32'd0);
        chk({tag, "_halted"},      {31'd0, halted},      32'd0);
        chk({tag, "_pc_addr"},     {26'd0, pc_addr},     32'd0);
        chk({tag, "_instr"},       instr,                32'd0);
        chk({tag, "_instr_pc"},    {26'd0, instr_pc},    32'd0);
    endtask

    // Monitor: every handshake must match the head of the scoreboard
    always @(negedge clk) begin
        if (prev_hs) chk("valid_drops_after_hs", {31'd0, instr_valid}, 32'd0);
        prev_hs <= instr_valid & instr_ready;
        if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_hs_pc", {26'd0, instr_pc}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("hs_instr_pc", {26'd0, instr_pc}, {26'd0, e.pc});
                chk("hs_instr", instr, word(e.pc));
                if (e.chk_inc) chk("hs_pc_inc", {31'd0, pc_inc}, {31'd0, e.inc});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] held;
        int n;
        rst_n = 1'b0; start = 1'b0; jump_en = 1'b0; jump_addr = '0; instr_ready = 1'b0;
        tick(); tick();
        check_reset_outputs("reset");

        // Basic fetch of 0,1,2 with decode always ready; latency from start
        push(6'd0, 1'b1, 1'b1); push(6'd1, 1'b1, 1'b1); push(6'd2, 1'b1, 1'b1);
        rst_n = 1'b1; start = 1'b1; instr_ready = 1'b1;
        tick(); start = 1'b0;
        chk("lat_req_mem_en", {31'd0, mem_en}, 32'd1);
        chk("lat_req_mem_addr", {26'd0, mem_addr}, 32'd0);
        tick();
        chk("lat_resp_mem_en", {31'd0, mem_en}, 32'd0);
        chk("lat_resp_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("lat_valid", {31'd0, instr_valid}, 32'd1);
        drain();
        instr_ready = 1'b0;

        // Stall 5 cycles at pc 3
        wait_valid();
        held = instr;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", instr, held);
            chk("stall_instr_pc", {26'd0, instr_pc}, 32'd3);
            chk("stall_pc", {26'd0, pc_addr}, 32'd3);
            chk("stall_pc_inc", {31'd0, pc_inc}, 32'd0);
            chk("stall_mem_en", {31'd0, mem_en}, 32'd0);
        end
        chk("stall_word", held, word(6'd3));

        // Release, then redirect to 0x20 during RESP of address 4
        push(6'd3, 1'b1, 1'b1); push(6'h20, 1'b1, 1'b1);
        instr_ready = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!(mem_en && mem_addr == 6'd4) && n < 20);
        chk("req4_seen", {31'd0, mem_en && mem_addr == 6'd4}, 32'd1);
        tick();
        jump_en = 1'b1; jump_addr = 6'h20;
        tick();
        jump_en = 1'b0;
        chk("flush_req_addr", {26'd0, mem_addr}, 32'h20);
        chk("flush_req_en", {31'd0, mem_en}, 32'd1);
        drain();
        instr_ready = 1'b0;

        // Jump ignored while stalled at 0x21, then taken on the handshake
        wait_valid();
        jump_en = 1'b1; jump_addr = 6'd7;
        tick(); tick();
        chk("jump_ignored_valid", {31'd0, instr_valid}, 32'd1);
        chk("jump_ignored_pc", {26'd0, pc_addr}, 32'h21);
        push(6'h21, 1'b0, 1'b1);
        instr_ready = 1'b1;
        tick();
        jump_en = 1'b0; instr_ready = 1'b0;
        chk("jump_hs_pc", {26'd0, pc_addr}, 32'd7);

        // Handshake with jump at pc 7 -> 0x10
        wait_valid();
        push(6'd7, 1'b0, 1'b1); push(6'h10, 1'b1, 1'b1);
        jump_en = 1'b1; jump_addr = 6'h10; instr_ready = 1'b1;
        tick();
        jump_en = 1'b0;
        drain();
        instr_ready = 1'b0;

        // Last address behaviour
        wait_valid();
        push(6'h11, 1'b0, 1'b1);
        jump_en = 1'b1; jump_addr = 6'd63; instr_ready = 1'b1;
        tick();
        jump_en = 1'b0;
`ifdef IB_FETCH_WRAP_EN
        push(6'd63, 1'b1, 1'b1); push(6'd0, 1'b1, 1'b1);
        drain();
        instr_ready = 1'b0;
        chk("wrap_halted", {31'd0, halted}, 32'd0);
        wait_valid();
        push(6'd1, 1'b0, 1'b1);
        jump_en = 1'b1; jump_addr = 6'd9; instr_ready = 1'b1;
        tick();
        jump_en = 1'b0; instr_ready = 1'b0;
`else
        push(6'd63, 1'b0, 1'b0);
        n = 0;
        while (!halted && n < 20) begin tick(); n++; end
        chk("halted", {31'd0, halted}, 32'd1);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            chk("halt_mem_en", {31'd0, mem_en}, 32'd0);
            chk("halt_valid", {31'd0, instr_valid}, 32'd0);
            chk("halt_held", {31'd0, halted}, 32'd1);
            chk("halt_pc", {26'd0, pc_addr}, 32'd63);
        end
        chk("halt_queue_empty", exp_q.size(), 32'd0);
        jump_en = 1'b1; jump_addr = 6'd9;
        tick();
        jump_en = 1'b0;
        chk("halt_exit_halted", {31'd0, halted}, 32'd0);
`endif

        // Reset in REQ at pc 9
        chk("req9_en", {31'd0, mem_en}, 32'd1);
        chk("req9_addr", {26'd0, mem_addr}, 32'd9);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midreset");
        push(6'd0, 1'b1, 1'b1);
        rst_n = 1'b1; start = 1'b1; instr_ready = 1'b1;
        tick();
        start = 1'b0;
        drain();
        instr_ready = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
